// File: rtl/counter_btn_conditioner.sv
// Push-button conditioner: per-channel 2-flop synchroniser, debounce filter,
// and press/auto-repeat FSM producing registered single-cycle step pulses.
module counter_btn_conditioner #(
   parameter int unsigned NUM_CH        = 2,
   parameter int unsigned DEB_CYCLES    = 8,
   parameter int unsigned REPEAT_DELAY  = 32,
   parameter int unsigned REPEAT_PERIOD = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [NUM_CH-1:0] btn_in,
   output logic [NUM_CH-1:0] level_out,
   output logic [NUM_CH-1:0] pulse_out,
   output logic [NUM_CH-1:0] held_out
);

   localparam int unsigned DebW   = $clog2(DEB_CYCLES + 1);
   localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RepW   = $clog2(RepMax + 1);

   // Counter values on the edge before a threshold is reached.
   localparam logic [DebW-1:0] DebLast    = DebW'(DEB_CYCLES - 1);
   localparam int unsigned     DelayLastI = (REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1;
   localparam logic [RepW-1:0] DelayLast  = RepW'(DelayLastI);
   localparam logic [RepW-1:0] PeriodLast = RepW'(REPEAT_PERIOD - 1);
   localparam logic            RepeatEn   = (REPEAT_DELAY != 0);

   typedef enum logic [1:0] {
      StIdle,
      StPressed,
      StRepeating
   } state_e;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic            sync1_q, sync2_q;
      logic            stable_q, stable_d;
      logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
      logic [RepW-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
      state_e          state_q, state_d;
      logic            pulse_q, pulse_d;
      logic            held_q, held_d;
      logic            rise, fall;

      // Two-flop synchroniser, free-running regardless of ena.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
         end else begin
            sync1_q <= btn_in[c];
            sync2_q <= sync1_q;
         end
      end

      // Debounce: stable flips after DEB_CYCLES consecutive differing samples.
      always_comb begin
         stable_d  = stable_q;
         deb_cnt_d = '0;
         if (ena && (sync2_q != stable_q)) begin
            if (deb_cnt_q == DebLast) begin
               stable_d = sync2_q;
            end else begin
               deb_cnt_d = deb_cnt_q + DebW'(1);
            end
         end
      end

      // Edges of the next stable value, so pulses line up with level_out.
      assign rise    = stable_d & ~stable_q;
      assign fall    = ~stable_d & stable_q;
      assign rep_inc = (rep_cnt_q == {RepW{1'b1}}) ? rep_cnt_q : rep_cnt_q + RepW'(1);

      // Press / auto-repeat FSM next-state and registered-output logic.
      always_comb begin
         state_d   = state_q;
         rep_cnt_d = rep_cnt_q;
         pulse_d   = 1'b0;
         if (!ena) begin
            state_d   = StIdle;
            rep_cnt_d = '0;
         end else if (fall) begin
            // Release wins over a repeat due on the same edge.
            state_d   = StIdle;
            rep_cnt_d = '0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  rep_cnt_d = '0;
                  if (rise) begin
                     pulse_d = 1'b1;
                     state_d = StPressed;
                  end
               end
               StPressed: begin
                  rep_cnt_d = rep_inc;
                  if (RepeatEn && (rep_cnt_q == DelayLast)) begin
                     pulse_d   = 1'b1;
                     rep_cnt_d = '0;
                     state_d   = StRepeating;
                  end
               end
               StRepeating: begin
                  rep_cnt_d = rep_inc;
                  if (rep_cnt_q == PeriodLast) begin
                     pulse_d   = 1'b1;
                     rep_cnt_d = '0;
                  end
               end
               default: begin
                  state_d   = StIdle;
                  rep_cnt_d = '0;
               end
            endcase
         end
         held_d = (state_d == StRepeating);
      end

      // Debounce, repeat counter, FSM and output registers.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            stable_q  <= 1'b0;
            deb_cnt_q <= '0;
            rep_cnt_q <= '0;
            state_q   <= StIdle;
            pulse_q   <= 1'b0;
            held_q    <= 1'b0;
         end else begin
            stable_q  <= stable_d;
            deb_cnt_q <= deb_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            state_q   <= state_d;
            pulse_q   <= pulse_d;
            held_q    <= held_d;
         end
      end

      assign level_out[c] = stable_q;
      assign pulse_out[c] = pulse_q;
      assign held_out[c]  = held_q;
   end

endmodule

// File: tb/tb_counter_btn_conditioner.sv
// Directed bench for counter_btn_conditioner with default parameters.
module tb_counter_btn_conditioner;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [1:0] btn_in;
   logic [1:0] level_out;
   logic [1:0] pulse_out;
   logic [1:0] held_out;

   int n_err;
   int n_checks;

   counter_btn_conditioner dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .btn_in    (btn_in),
      .level_out (level_out),
      .pulse_out (pulse_out),
      .held_out  (held_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic [1:0] lvl, input logic [1:0] pls,
                          input logic [1:0] hld);
      chk({tag, ".level"}, level_out, lvl);
      chk({tag, ".pulse"}, pulse_out, pls);
      chk({tag, ".held"}, held_out, hld);
   endtask

   initial begin
      n_err    = 0;
      n_checks = 0;
      rst_n    = 1'b0;
      ena      = 1'b1;
      btn_in   = 2'b00;

      // Reset state
      step();
      step();
      chk_all("reset", 2'b00, 2'b00, 2'b00);
      rst_n = 1'b1;
      step();
      step();
      chk_all("idle", 2'b00, 2'b00, 2'b00);

      // 1. Press ch0: level and pulse rise on the 10th edge
      btn_in = 2'b01;
      for (int i = 1; i <= 9; i++) begin
         step();
         chk_all("press0.wait", 2'b00, 2'b00, 2'b00);
      end
      step();
      chk_all("press0.edge", 2'b01, 2'b01, 2'b00);

      // 3. Hold: repeats at +32, +40 ... +96
      for (int t = 1; t <= 100; t++) begin
         step();
         chk_all("hold0", 2'b01, (t >= 32 && ((t - 32) % 8) == 0) ? 2'b01 : 2'b00,
                 (t >= 32) ? 2'b01 : 2'b00);
      end
      // Release sampled at +101, stable falls at +110; repeat at +104 still due
      btn_in = 2'b00;
      for (int t = 101; t <= 115; t++) begin
         step();
         chk_all("release0", (t < 110) ? 2'b01 : 2'b00, (t == 104) ? 2'b01 : 2'b00,
                 (t < 110) ? 2'b01 : 2'b00);
      end

      // 2. Bounce: 3-cycle toggles never qualify
      for (int r = 0; r < 4; r++) begin
         btn_in = ((r % 2) == 0) ? 2'b01 : 2'b00;
         for (int i = 0; i < 3; i++) begin
            step();
            chk_all("bounce", 2'b00, 2'b00, 2'b00);
         end
      end
      btn_in = 2'b01;
      for (int i = 1; i <= 9; i++) begin
         step();
         chk_all("bounce.settle", 2'b00, 2'b00, 2'b00);
      end
      step();
      chk_all("bounce.press", 2'b01, 2'b01, 2'b00);

      // 4. Release so stable falls on the +40 repeat edge: no pulse there
      for (int t = 1; t <= 30; t++) begin
         step();
         chk("collide.pre.pulse", pulse_out, 2'b00);
      end
      btn_in = 2'b00;
      for (int t = 31; t <= 42; t++) begin
         step();
         chk_all("collide", (t < 40) ? 2'b01 : 2'b00, (t == 32) ? 2'b01 : 2'b00,
                 (t >= 32 && t < 40) ? 2'b01 : 2'b00);
      end

      // 5. ena low while ch1 held
      btn_in = 2'b10;
      for (int i = 1; i <= 9; i++) begin
         step();
         chk("press1.wait.pulse", pulse_out, 2'b00);
      end
      step();
      chk_all("press1.edge", 2'b10, 2'b10, 2'b00);
      ena = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         chk_all("ena_low", 2'b10, 2'b00, 2'b00);
      end
      ena = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step();
         chk_all("ena_rise", 2'b10, 2'b00, 2'b00);
      end
      btn_in = 2'b00;
      for (int i = 1; i <= 9; i++) begin
         step();
         chk_all("release1.wait", 2'b10, 2'b00, 2'b00);
      end
      step();
      chk_all("release1.edge", 2'b00, 2'b00, 2'b00);
      btn_in = 2'b10;
      for (int i = 1; i <= 9; i++) begin
         step();
         chk_all("repress1.wait", 2'b00, 2'b00, 2'b00);
      end
      step();
      chk_all("repress1.edge", 2'b10, 2'b10, 2'b00);

      // 6. Reset mid-repeat with ch1 held
      for (int t = 1; t <= 35; t++) begin
         step();
         chk_all("hold1", 2'b10, (t == 32) ? 2'b10 : 2'b00, (t >= 32) ? 2'b10 : 2'b00);
      end
      rst_n = 1'b0;
      #1;
      chk_all("async_reset", 2'b00, 2'b00, 2'b00);
      for (int i = 0; i < 3; i++) begin
         step();
         chk_all("in_reset", 2'b00, 2'b00, 2'b00);
      end
      rst_n = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         step();
         chk_all("post_reset.wait", 2'b00, 2'b00, 2'b00);
      end
      step();
      chk_all("post_reset.press", 2'b10, 2'b10, 2'b00);
      for (int t = 1; t <= 32; t++) begin
         step();
         chk_all("post_reset.hold", 2'b10, (t == 32) ? 2'b10 : 2'b00,
                 (t >= 32) ? 2'b10 : 2'b00);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
